warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
Control sequencer for a multi-warp compute core. It generalises the single-PC, single-thread-group core control flow to NUM_WARPS independent warps, each with its own PC and enable mask. Warps are interleaved round-robin at instruction granularity. It drives core_state, current_pc and the active warp/thread mask consumed by the fetcher, decoder, and per-thread ALU/LSU/register files.

Parameters:
THREADS_PER_WARP, 4, threads (ALU/LSU lanes) per warp
NUM_WARPS, 2, warps resident in the core (>=1)
PC_BITS, 8, program counter width
WARP_BITS, max(1,$clog2(NUM_WARPS)), warp index width (derived, localparam)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  kernel start pulse; sampled only in IDLE
thread_count  input  $clog2(NUM_WARPS*THREADS_PER_WARP)+1  enabled threads in block; sampled on start
fetcher_state  input  3  fetcher FSM state; 3'b010 = FETCHED
decoded_mem_read_enable  input  1  current instruction is a load
decoded_mem_write_enable  input  1  current instruction is a store
decoded_ret  input  1  current instruction is RET
lsu_state  input  2*THREADS_PER_WARP  per-lane LSU state, lane t at [2t+1:2t]; 0 IDLE, 1 REQUESTING, 2 WAITING, 3 DONE
next_pc  input  PC_BITS*THREADS_PER_WARP  per-lane next PC, lane t at [PC_BITS*t +: PC_BITS]
core_state  output  3  0 IDLE, 1 FETCH, 2 DECODE, 3 REQUEST, 4 WAIT, 5 EXECUTE, 6 UPDATE, 7 DONE
current_pc  output  PC_BITS  PC of active warp
active_warp  output  WARP_BITS  index of warp being executed
thread_mask  output  THREADS_PER_WARP  enabled lanes of active warp
diverged  output  1  sticky: enabled lanes disagreed on next_pc
done  output  1  high in DONE state

Behaviour:
- All outputs are registered. On reset:
  - core_state=IDLE, current_pc=0, active_warp=0, thread_mask=0, diverged=0, done=0.
  - All warp PCs = 0; all warp finished flags = 0.
  - Reset takes priority in any state, including mid-WAIT; the next edge after reset deasserts sees IDLE.
- Lane enable: global thread index g = w*THREADS_PER_WARP + t is enabled iff g < latched thread_count. A warp with no enabled lanes is marked finished at start.
- IDLE:
  - start=1 latches thread_count, computes finished flags and clears diverged.
  - If any warp is unfinished: go to FETCH with active_warp = lowest unfinished warp and its thread_mask and PC loaded.
  - Otherwise go to DONE.
  - start in any other state is ignored.
- FETCH: hold until fetcher_state==3'b010, then go to DECODE on the next edge.
- DECODE: 1 cycle, then REQUEST.
- REQUEST: 1 cycle, then WAIT.
- WAIT:
  - Hold while any enabled lane has lsu_state REQUESTING or WAITING. Otherwise go to EXECUTE.
  - Disabled lanes' lsu_state is ignored.
  - With no memory op, WAIT lasts exactly 1 cycle.
- EXECUTE: 1 cycle, then UPDATE.
- UPDATE:
  - If decoded_ret=1: mark active warp finished; its PC is unchanged.
  - Otherwise: warp PC <= next_pc of the lowest-index enabled lane.
  - If any enabled lane's next_pc differs from that value, set diverged (sticky until reset or the next accepted start).
- Warp selection in UPDATE:
  - Next warp = first unfinished warp scanning active_warp+1, active_warp+2, … modulo NUM_WARPS, wrapping around and including the current warp last.
  - current_pc and thread_mask are loaded for that warp, same edge; then go to FETCH.
  - If no unfinished warp remains, go to DONE.
- DONE: done=1 and the state holds until reset.
- Minimum instruction latency with a 1-cycle fetch response is 6 cycles: FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE.
- PC arithmetic: PC wrap-around is the ALU/next_pc source's concern. This block stores next_pc verbatim, PC_BITS wide.
- NUM_WARPS=1: active_warp is constant 0, and behaviour is identical to single-warp sequencing.

Test Plan:
1. Round-robin interleave. NUM_WARPS=2, THREADS_PER_WARP=4, thread_count=8. Fetcher returns FETCHED 1 cycle after FETCH; next_pc=pc+1 on all lanes; RET at pc 3.
   -> active_warp sequence 0,1,0,1,… with PCs 0,0,1,1,2,2,3,3; done=1 after both RETs; diverged=0.
2. Partial warp, thread_count=5.
   -> warp0 thread_mask=4'b1111, warp1 thread_mask=4'b0001; lsu_state and next_pc of warp1 lanes 1–3 are ignored.
3. Empty kernel, thread_count=0 and start.
   -> IDLE goes to DONE on the next edge; done=1; FETCH is never entered.
4. Memory stall. Load instruction with lane 2 lsu_state=WAITING for 5 cycles, then DONE.
   -> core_state=4 for exactly 5 cycles, then EXECUTE on the following edge. Forcing lane 3 to WAITING while thread_count=3 causes no stall.
5. Divergence. next_pc lane0=5, lane1=9, all lanes enabled.
   -> warp PC becomes 5; diverged=1 and stays 1 across subsequent instructions until reset.
6. Reset mid-operation. Assert reset during WAIT with warp1 active.
   -> next cycle all outputs are at reset values; a new start runs from pc 0 with warp 0 first.

Source files
------------

// File: rtl/warp_scheduler.sv
// warp_scheduler: round-robin multi-warp core sequencer; per-warp PC and finished flags,
// instruction-granular interleave, lane masking from the launched thread count.
module warp_scheduler #(
   parameter  int THREADS_PER_WARP = 4,
   parameter  int NUM_WARPS        = 2,
   parameter  int PC_BITS          = 8,
   localparam int WARP_BITS        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int TC_BITS          = $clog2(NUM_WARPS * THREADS_PER_WARP) + 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [TC_BITS-1:0]                   thread_count,
   input  logic [2:0]                           fetcher_state,
   input  logic                                 decoded_mem_read_enable,
   input  logic                                 decoded_mem_write_enable,
   input  logic                                 decoded_ret,
   input  logic [2*THREADS_PER_WARP-1:0]        lsu_state,
   input  logic [PC_BITS*THREADS_PER_WARP-1:0]  next_pc,
   output logic [2:0]                           core_state,
   output logic [PC_BITS-1:0]                   current_pc,
   output logic [WARP_BITS-1:0]                 active_warp,
   output logic [THREADS_PER_WARP-1:0]          thread_mask,
   output logic                                 diverged,
   output logic                                 done
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_REQUEST, S_WAIT, S_EXECUTE, S_UPDATE, S_DONE
   } state_t;

   state_t                          r_state;
   logic [PC_BITS-1:0]              r_pcs [NUM_WARPS];
   logic [NUM_WARPS-1:0]            r_fin;
   logic [TC_BITS-1:0]              r_tc;
   logic [PC_BITS-1:0]              r_pc;
   logic [WARP_BITS-1:0]            r_warp;
   logic [THREADS_PER_WARP-1:0]     r_mask;
   logic                            r_div;
   logic                            r_done;

   logic [NUM_WARPS-1:0]            w_start_fin;
   logic [WARP_BITS-1:0]            w_first;
   logic                            w_any_start;
   logic                            w_mem;
   logic                            w_busy;
   logic [PC_BITS-1:0]              w_lead_pc;
   logic                            w_div;
   logic [NUM_WARPS-1:0]            w_fin_upd;
   logic [PC_BITS-1:0]              w_pc_upd [NUM_WARPS];
   logic [WARP_BITS-1:0]            w_next_warp;
   logic                            w_any_next;

   // Global thread g = w*THREADS_PER_WARP + t is live iff g < tc.
   function automatic logic [THREADS_PER_WARP-1:0] lane_mask(input int w, input logic [TC_BITS-1:0] tc);
      logic [THREADS_PER_WARP-1:0] m;
      for (int t = 0; t < THREADS_PER_WARP; t++)
         m[t] = (w * THREADS_PER_WARP + t) < int'(tc);
      return m;
   endfunction

   assign core_state  = r_state;
   assign current_pc  = r_pc;
   assign active_warp = r_warp;
   assign thread_mask = r_mask;
   assign diverged    = r_div;
   assign done        = r_done;
   assign w_mem       = decoded_mem_read_enable | decoded_mem_write_enable;

   always_comb begin
      w_start_fin = '0;
      w_first     = '0;
      w_any_start = 1'b0;
      for (int w = NUM_WARPS - 1; w >= 0; w--) begin
         w_start_fin[w] = ~|lane_mask(w, thread_count);
         if (!w_start_fin[w]) begin
            w_first     = WARP_BITS'(w);
            w_any_start = 1'b1;
         end
      end
      w_lead_pc = '0;
      for (int t = THREADS_PER_WARP - 1; t >= 0; t--)
         if (r_mask[t]) w_lead_pc = next_pc[t*PC_BITS +: PC_BITS];
      w_busy = 1'b0;
      w_div  = 1'b0;
      for (int t = 0; t < THREADS_PER_WARP; t++) begin
         w_busy = w_busy | (r_mask[t] & (lsu_state[2*t +: 2] == 2'd1 || lsu_state[2*t +: 2] == 2'd2));
         w_div  = w_div  | (r_mask[t] & (next_pc[t*PC_BITS +: PC_BITS] != w_lead_pc));
      end
      w_fin_upd = r_fin;
      w_pc_upd  = r_pcs;
      if (decoded_ret) w_fin_upd[r_warp] = 1'b1;
      else             w_pc_upd[r_warp]  = w_lead_pc;
      // Descending scan so the smallest offset from the current warp wins; offset NUM_WARPS is the current warp.
      w_next_warp = '0;
      w_any_next  = 1'b0;
      for (int i = NUM_WARPS; i >= 1; i--)
         if (!w_fin_upd[(int'(r_warp) + i) % NUM_WARPS]) begin
            w_next_warp = WARP_BITS'((int'(r_warp) + i) % NUM_WARPS);
            w_any_next  = 1'b1;
         end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_warp  <= '0;
         r_mask  <= '0;
         r_div   <= 1'b0;
         r_done  <= 1'b0;
         r_fin   <= '0;
         r_tc    <= '0;
         for (int w = 0; w < NUM_WARPS; w++) r_pcs[w] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_tc  <= thread_count;
               r_fin <= w_start_fin;
               r_div <= 1'b0;
               if (w_any_start) begin
                  r_state <= S_FETCH;
                  r_warp  <= w_first;
                  r_mask  <= lane_mask(int'(w_first), thread_count);
                  r_pc    <= r_pcs[w_first];
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_FETCH:   if (fetcher_state == 3'b010) r_state <= S_DECODE;
            S_DECODE:  r_state <= S_REQUEST;
            S_REQUEST: r_state <= S_WAIT;
            S_WAIT:    if (!(w_mem && w_busy)) r_state <= S_EXECUTE;
            S_EXECUTE: r_state <= S_UPDATE;
            S_UPDATE: begin
               r_fin <= w_fin_upd;
               r_pcs <= w_pc_upd;
               if (w_div) r_div <= 1'b1;
               if (w_any_next) begin
                  r_state <= S_FETCH;
                  r_warp  <= w_next_warp;
                  r_mask  <= lane_mask(int'(w_next_warp), r_tc);
                  r_pc    <= w_pc_upd[w_next_warp];
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: r_done <= 1'b1;
         endcase
      end
   end
endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: directed scenario tasks for warp_scheduler (2 warps x 4 lanes, 8-bit PC).
module tb_warp_scheduler;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  thread_count = '0;
   logic [2:0]  fetcher_state = '0;
   logic        decoded_mem_read_enable = 1'b0;
   logic        decoded_mem_write_enable = 1'b0;
   logic        decoded_ret = 1'b0;
   logic [7:0]  lsu_state = '0;
   logic [31:0] next_pc = '0;
   logic [2:0]  core_state;
   logic [7:0]  current_pc;
   logic [0:0]  active_warp;
   logic [3:0]  thread_mask;
   logic        diverged;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   warp_scheduler #(.THREADS_PER_WARP(4), .NUM_WARPS(2), .PC_BITS(8)) dut (
      .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
      .fetcher_state(fetcher_state), .decoded_mem_read_enable(decoded_mem_read_enable),
      .decoded_mem_write_enable(decoded_mem_write_enable), .decoded_ret(decoded_ret),
      .lsu_state(lsu_state), .next_pc(next_pc), .core_state(core_state),
      .current_pc(current_pc), .active_warp(active_warp), .thread_mask(thread_mask),
      .diverged(diverged), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] fill(input logic [7:0] p);
      return {4{p}};
   endfunction

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; fetcher_state = '0; decoded_ret = 1'b0;
      decoded_mem_read_enable = 1'b0; decoded_mem_write_enable = 1'b0;
      lsu_state = '0; next_pc = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic launch(input logic [3:0] tc);
      thread_count = tc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs one instruction from FETCH to the edge after UPDATE; reports what the DUT showed.
   task automatic do_instr(input logic [31:0] npc, input logic ret, input logic mem,
                           input int sl, input int sc,
                           output logic [0:0] ow, output logic [7:0] opc, output logic [3:0] om,
                           output int owait, output logic ok);
      int k;
      ow = active_warp; opc = current_pc; om = thread_mask; owait = 0;
      ok = (core_state == 3'd1);
      fetcher_state = 3'b001;
      tick();
      ok &= (core_state == 3'd1);
      fetcher_state = 3'b010; next_pc = npc; decoded_ret = ret; decoded_mem_read_enable = mem;
      tick();
      ok &= (core_state == 3'd2);
      fetcher_state = 3'b000;
      tick();
      ok &= (core_state == 3'd3);
      k = 0;
      while ((core_state == 3'd3 || core_state == 3'd4) && k < 60) begin
         lsu_state = '0;
         lsu_state[2*sl +: 2] = (k < sc) ? 2'd2 : 2'd3;
         if (core_state == 3'd4) owait++;
         tick();
         k++;
      end
      ok &= (core_state == 3'd5);
      lsu_state = '0;
      tick();
      ok &= (core_state == 3'd6);
      tick();
      ok &= (core_state == 3'd1 || core_state == 3'd7);
      decoded_ret = 1'b0; decoded_mem_read_enable = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (core_state !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", core_state); end
      n_vec++; if (current_pc !== 8'd0) begin n_err++; $display("FAIL reset_pc got %0d exp 0", current_pc); end
      n_vec++; if (active_warp !== 1'b0) begin n_err++; $display("FAIL reset_warp got %0d exp 0", active_warp); end
      n_vec++; if (thread_mask !== 4'b0) begin n_err++; $display("FAIL reset_mask got %b exp 0000", thread_mask); end
      n_vec++; if (diverged !== 1'b0) begin n_err++; $display("FAIL reset_div got %b exp 0", diverged); end
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
   endtask

   task automatic test_round_robin();
      logic [0:0] ow; logic [7:0] opc; logic [3:0] om; int ow8; logic ok;
      logic [7:0] epc;
      do_reset();
      launch(4'd8);
      n_vec++; if (thread_mask !== 4'b1111) begin n_err++; $display("FAIL rr_mask0 got %b exp 1111", thread_mask); end
      for (int i = 0; i < 8; i++) begin
         epc = 8'(i / 2);
         do_instr(fill(epc + 8'd1), epc == 8'd3, 1'b0, 0, 0, ow, opc, om, ow8, ok);
         n_vec++; if (ow !== 1'(i % 2)) begin n_err++; $display("FAIL rr_warp[%0d] got %0d exp %0d", i, ow, i % 2); end
         n_vec++; if (opc !== epc) begin n_err++; $display("FAIL rr_pc[%0d] got %0d exp %0d", i, opc, epc); end
         n_vec++; if (ow8 !== 1) begin n_err++; $display("FAIL rr_wait[%0d] got %0d exp 1", i, ow8); end
         n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL rr_seq[%0d] got %b exp 1", i, ok); end
      end
      n_vec++; if (core_state !== 3'd7) begin n_err++; $display("FAIL rr_state got %0d exp 7", core_state); end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL rr_done got %b exp 1", done); end
      n_vec++; if (diverged !== 1'b0) begin n_err++; $display("FAIL rr_div got %b exp 0", diverged); end
      launch(4'd8);
      n_vec++; if (core_state !== 3'd7) begin n_err++; $display("FAIL rr_start_in_done got %0d exp 7", core_state); end
   endtask

   task automatic test_partial();
      logic [0:0] ow; logic [7:0] opc; logic [3:0] om; int ow8; logic ok;
      do_reset();
      launch(4'd5);
      do_instr(fill(8'd1), 1'b0, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      n_vec++; if (om !== 4'b1111) begin n_err++; $display("FAIL part_mask0 got %b exp 1111", om); end
      n_vec++; if (thread_mask !== 4'b0001) begin n_err++; $display("FAIL part_mask1 got %b exp 0001", thread_mask); end
      n_vec++; if (active_warp !== 1'b1) begin n_err++; $display("FAIL part_warp1 got %0d exp 1", active_warp); end
      do_instr({8'hAA, 8'hAA, 8'hAA, 8'd1}, 1'b0, 1'b1, 2, 8, ow, opc, om, ow8, ok);
      n_vec++; if (ow8 !== 1) begin n_err++; $display("FAIL part_wait got %0d exp 1", ow8); end
      n_vec++; if (diverged !== 1'b0) begin n_err++; $display("FAIL part_div got %b exp 0", diverged); end
      n_vec++; if (current_pc !== 8'd1 || active_warp !== 1'b0) begin n_err++; $display("FAIL part_next got w%0d pc%0d exp w0 pc1", active_warp, current_pc); end
      do_instr(fill(8'd2), 1'b1, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      n_vec++; if (current_pc !== 8'd1 || active_warp !== 1'b1) begin n_err++; $display("FAIL part_w1pc got w%0d pc%0d exp w1 pc1", active_warp, current_pc); end
      do_instr({8'hAA, 8'hAA, 8'hAA, 8'd2}, 1'b1, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      n_vec++; if (done !== 1'b1 || core_state !== 3'd7) begin n_err++; $display("FAIL part_done got done%b st%0d exp done1 st7", done, core_state); end
   endtask

   task automatic test_empty();
      logic saw_fetch;
      do_reset();
      launch(4'd0);
      n_vec++; if (core_state !== 3'd7) begin n_err++; $display("FAIL empty_state got %0d exp 7", core_state); end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL empty_done got %b exp 1", done); end
      n_vec++; if (thread_mask !== 4'b0) begin n_err++; $display("FAIL empty_mask got %b exp 0000", thread_mask); end
      saw_fetch = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (core_state != 3'd7) saw_fetch = 1'b1;
      end
      n_vec++; if (saw_fetch !== 1'b0) begin n_err++; $display("FAIL empty_hold got left_done=%b exp 0", saw_fetch); end
   endtask

   task automatic test_mem_stall();
      logic [0:0] ow; logic [7:0] opc; logic [3:0] om; int ow8; logic ok;
      do_reset();
      launch(4'd8);
      do_instr(fill(8'd1), 1'b0, 1'b1, 2, 5, ow, opc, om, ow8, ok);
      n_vec++; if (ow8 !== 5) begin n_err++; $display("FAIL stall_wait got %0d exp 5", ow8); end
      n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL stall_seq got %b exp 1", ok); end
      n_vec++; if (active_warp !== 1'b1) begin n_err++; $display("FAIL stall_next got %0d exp 1", active_warp); end
      do_reset();
      launch(4'd3);
      n_vec++; if (thread_mask !== 4'b0111) begin n_err++; $display("FAIL stall3_mask got %b exp 0111", thread_mask); end
      do_instr(fill(8'd1), 1'b0, 1'b1, 3, 5, ow, opc, om, ow8, ok);
      n_vec++; if (ow8 !== 1) begin n_err++; $display("FAIL stall3_wait got %0d exp 1", ow8); end
      n_vec++; if (active_warp !== 1'b0 || current_pc !== 8'd1) begin n_err++; $display("FAIL stall3_next got w%0d pc%0d exp w0 pc1", active_warp, current_pc); end
   endtask

   task automatic test_divergence();
      logic [0:0] ow; logic [7:0] opc; logic [3:0] om; int ow8; logic ok;
      do_reset();
      launch(4'd8);
      do_instr({8'd5, 8'd5, 8'd9, 8'd5}, 1'b0, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      n_vec++; if (diverged !== 1'b1) begin n_err++; $display("FAIL div_set got %b exp 1", diverged); end
      do_instr(fill(8'd1), 1'b0, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      n_vec++; if (current_pc !== 8'd5 || active_warp !== 1'b0) begin n_err++; $display("FAIL div_pc got w%0d pc%0d exp w0 pc5", active_warp, current_pc); end
      n_vec++; if (diverged !== 1'b1) begin n_err++; $display("FAIL div_sticky1 got %b exp 1", diverged); end
      do_instr(fill(8'd6), 1'b0, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      n_vec++; if (diverged !== 1'b1) begin n_err++; $display("FAIL div_sticky2 got %b exp 1", diverged); end
      n_vec++; if (current_pc !== 8'd1 || active_warp !== 1'b1) begin n_err++; $display("FAIL div_w1 got w%0d pc%0d exp w1 pc1", active_warp, current_pc); end
   endtask

   task automatic test_reset_mid();
      logic [0:0] ow; logic [7:0] opc; logic [3:0] om; int ow8; logic ok;
      do_reset();
      launch(4'd8);
      do_instr(fill(8'd4), 1'b0, 1'b0, 0, 0, ow, opc, om, ow8, ok);
      fetcher_state = 3'b010;
      tick();
      fetcher_state = 3'b000; decoded_mem_read_enable = 1'b1; lsu_state = 8'b0000_0010;
      tick();
      tick();
      tick();
      n_vec++; if (core_state !== 3'd4 || active_warp !== 1'b1) begin n_err++; $display("FAIL mid_wait got st%0d w%0d exp st4 w1", core_state, active_warp); end
      reset = 1'b1;
      tick();
      reset = 1'b0; lsu_state = '0; decoded_mem_read_enable = 1'b0;
      n_vec++; if (core_state !== 3'd0 || current_pc !== 8'd0 || active_warp !== 1'b0) begin n_err++; $display("FAIL mid_rst got st%0d pc%0d w%0d exp 0 0 0", core_state, current_pc, active_warp); end
      n_vec++; if (thread_mask !== 4'b0 || diverged !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got m%b d%b dn%b exp 0", thread_mask, diverged, done); end
      tick();
      n_vec++; if (core_state !== 3'd0) begin n_err++; $display("FAIL mid_idle got %0d exp 0", core_state); end
      launch(4'd8);
      n_vec++; if (core_state !== 3'd1 || active_warp !== 1'b0 || current_pc !== 8'd0) begin n_err++; $display("FAIL mid_restart got st%0d w%0d pc%0d exp 1 0 0", core_state, active_warp, current_pc); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_partial();
      test_empty();
      test_mem_stall();
      test_divergence();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
